// File: rtl/commit_stream_monitor.sv
// commit_stream_monitor
// Retirement monitor that watches the processor commit stream. Checks that
// commits arrive in order, packed from lane 0, with ROB ids wrapping at NO_ROB;
// counts retirements, raises done after NO_INSTR retirements and trips a
// watchdog after TIMEOUT_CYCLES consecutive commit-free cycles.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   enable           start monitoring (sampled in IDLE only)
//   flush            pipeline flush: drop id sync, restart watchdog
//   commit_valid     per-lane commit strobe, lane 0 oldest
//   commit_rob_id    packed lane ids, lane i at [i*ROB_W +: ROB_W]
//   state            0=IDLE 1=RUN 2=DONE 3=FAIL
//   retired_count    instructions retired while in RUN (saturating)
//   expected_rob_id  next id expected on lane 0
//   cycle_count      cycles spent in RUN (saturating)
//   order_error      sticky: lane id mismatch
//   gap_error        sticky: non-contiguous commit mask
//   timeout          sticky: watchdog expired
//   first_err_cycle  cycle_count at the first error
//   done             level, state == DONE
//   done_pulse       one-cycle pulse on entry to DONE
module commit_stream_monitor #(
    parameter int unsigned ISSUE_WIDTH    = 3,
    parameter int unsigned NO_ROB         = 48,
    parameter int unsigned NO_INSTR       = 33,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ROB_W          = $clog2(NO_ROB)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [ISSUE_WIDTH-1:0]       commit_valid,
    input  logic [ISSUE_WIDTH*ROB_W-1:0] commit_rob_id,
    output logic [1:0]                   state,
    output logic [31:0]                  retired_count,
    output logic [ROB_W-1:0]             expected_rob_id,
    output logic [31:0]                  cycle_count,
    output logic                         order_error,
    output logic                         gap_error,
    output logic                         timeout,
    output logic [31:0]                  first_err_cycle,
    output logic                         done,
    output logic                         done_pulse
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned LANE_W = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned SUM_W  = ROB_W + LANE_W;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                synced_q, synced_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [CNT_W-1:0]    retired_d, cycle_d, first_err_d;
    logic [ROB_W-1:0]    exp_d;
    logic                order_d, gap_d, timeout_d, done_d, done_pulse_d;

    logic [LANE_W-1:0]   n_valid;
    logic                hole;
    logic                gap_hit;
    logic                ord_hit;
    logic                tmo_hit;
    logic [ROB_W-1:0]    base_id;
    logic [ROB_W-1:0]    next_base;
    logic [CNT_W:0]      retired_sum;
    logic [CNT_W-1:0]    retired_sat;
    logic [CNT_W-1:0]    cycle_sat;
    logic [IDLE_W-1:0]   idle_inc;
    logic                reach_done;

    // (b + k) mod NO_ROB by a single compare-and-subtract; k < NO_ROB
    function automatic logic [ROB_W-1:0] wrap_add(input logic [ROB_W-1:0] b,
                                                  input logic [LANE_W-1:0] k);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(b) + SUM_W'(k);
        if (sum >= SUM_W'(NO_ROB)) begin
            sum = sum - SUM_W'(NO_ROB);
        end
        return ROB_W'(sum);
    endfunction

    // Per-cycle checks of the commit bundle against the expected id sequence
    always_comb begin
        n_valid = '0;
        hole    = 1'b0;
        gap_hit = 1'b0;
        ord_hit = 1'b0;
        // Unsynced: lane 0 defines the base, so the first commit self-syncs
        base_id = synced_q ? expected_rob_id : commit_rob_id[ROB_W-1:0];
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (commit_valid[i]) begin
                n_valid = n_valid + LANE_W'(1);
                if (hole) begin
                    gap_hit = 1'b1;
                end
                if (commit_rob_id[i*ROB_W +: ROB_W] != wrap_add(base_id, LANE_W'(i))) begin
                    ord_hit = 1'b1;
                end
            end else begin
                hole = 1'b1;
            end
        end
        next_base   = wrap_add(base_id, n_valid);
        retired_sum = {1'b0, retired_count} + (CNT_W + 1)'(n_valid);
        retired_sat = retired_sum[CNT_W] ? '1 : retired_sum[CNT_W-1:0];
        cycle_sat   = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
        idle_inc    = idle_q + IDLE_W'(1);
        // A flush restarts the watchdog, so it cannot expire in that cycle
        tmo_hit     = (n_valid == '0) && !flush && (idle_inc == IDLE_W'(TIMEOUT_CYCLES));
        reach_done  = (retired_sum >= (CNT_W + 1)'(NO_INSTR));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        synced_d     = synced_q;
        idle_d       = idle_q;
        retired_d    = retired_count;
        exp_d        = expected_rob_id;
        cycle_d      = cycle_count;
        order_d      = order_error;
        gap_d        = gap_error;
        timeout_d    = timeout;
        first_err_d  = first_err_cycle;
        done_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                synced_d    = 1'b0;
                idle_d      = '0;
                retired_d   = '0;
                exp_d       = '0;
                cycle_d     = '0;
                order_d     = 1'b0;
                gap_d       = 1'b0;
                timeout_d   = 1'b0;
                first_err_d = '0;
                if (enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cycle_d = cycle_sat;
                if (gap_hit || ord_hit || tmo_hit) begin
                    // Flags are clear in RUN, so this is always the first error
                    gap_d       = gap_hit;
                    order_d     = ord_hit;
                    timeout_d   = tmo_hit;
                    first_err_d = cycle_count;
                    state_d     = S_FAIL;
                end else if (n_valid != '0) begin
                    retired_d = retired_sat;
                    exp_d     = next_base;
                    synced_d  = 1'b1;
                    idle_d    = '0;
                    if (reach_done) begin
                        state_d      = S_DONE;
                        done_pulse_d = 1'b1;
                    end
                end else begin
                    idle_d = idle_inc;
                end
                // Commit above was checked against the old sync; flush wins after
                if (flush) begin
                    synced_d = 1'b0;
                    idle_d   = '0;
                end
            end
            default: begin
                // DONE and FAIL are absorbing with everything frozen
            end
        endcase

        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            synced_q        <= 1'b0;
            idle_q          <= '0;
            retired_count   <= '0;
            expected_rob_id <= '0;
            cycle_count     <= '0;
            order_error     <= 1'b0;
            gap_error       <= 1'b0;
            timeout         <= 1'b0;
            first_err_cycle <= '0;
            done            <= 1'b0;
            done_pulse      <= 1'b0;
        end else begin
            state_q         <= state_d;
            synced_q        <= synced_d;
            idle_q          <= idle_d;
            retired_count   <= retired_d;
            expected_rob_id <= exp_d;
            cycle_count     <= cycle_d;
            order_error     <= order_d;
            gap_error       <= gap_d;
            timeout         <= timeout_d;
            first_err_cycle <= first_err_d;
            done            <= done_d;
            done_pulse      <= done_pulse_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_commit_stream_monitor.sv
// Testbench for commit_stream_monitor: directed vector table, hand-written
// watchdog sequences, and randomized commit streams checked against a
// behavioural model of the retirement rules.
module tb_commit_stream_monitor;

    localparam int unsigned IW      = 3;
    localparam int unsigned NROB    = 48;
    localparam int unsigned NINSTR  = 33;
    localparam int unsigned TMO     = 1024;
    localparam int unsigned RW      = $clog2(NROB);

    logic              clk;
    logic              rst;
    logic              enable;
    logic              flush;
    logic [IW-1:0]     commit_valid;
    logic [IW*RW-1:0]  commit_rob_id;
    logic [1:0]        state;
    logic [31:0]       retired_count;
    logic [RW-1:0]     expected_rob_id;
    logic [31:0]       cycle_count;
    logic              order_error;
    logic              gap_error;
    logic              timeout;
    logic [31:0]       first_err_cycle;
    logic              done;
    logic              done_pulse;

    commit_stream_monitor #(
        .ISSUE_WIDTH   (IW),
        .NO_ROB        (NROB),
        .NO_INSTR      (NINSTR),
        .TIMEOUT_CYCLES(TMO),
        .ROB_W         (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .flush          (flush),
        .commit_valid   (commit_valid),
        .commit_rob_id  (commit_rob_id),
        .state          (state),
        .retired_count  (retired_count),
        .expected_rob_id(expected_rob_id),
        .cycle_count    (cycle_count),
        .order_error    (order_error),
        .gap_error      (gap_error),
        .timeout        (timeout),
        .first_err_cycle(first_err_cycle),
        .done           (done),
        .done_pulse     (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_state, m_retired, m_exp, m_cycle, m_ferr, m_idle;
    bit m_order, m_gap, m_tmo, m_dp, m_synced;

    typedef struct {
        logic       rst;
        logic       en;
        logic       fl;
        logic [2:0] v;
        int         i0, i1, i2;
        int         st, ret, eid;
        logic [2:0] flg;   // {timeout, gap, order}
        logic       dp;
        int         cyc, ferr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ids(input int a, input int b, input int c);
        commit_rob_id = {RW'(c), RW'(b), RW'(a)};
    endtask

    // Model: one clock of the retirement rules with the inputs currently driven
    task automatic model_step();
        int  n, base, v;
        bit  g, o, t;
        m_dp = 1'b0;
        if (rst) begin
            m_state = 0; m_retired = 0; m_exp = 0; m_cycle = 0; m_ferr = 0;
            m_idle = 0; m_order = 0; m_gap = 0; m_tmo = 0; m_synced = 0;
            return;
        end
        if (m_state == 0) begin
            if (enable) m_state = 1;
        end else if (m_state == 1) begin
            v    = int'(commit_valid);
            n    = $countones(commit_valid);
            g    = ((v & (v + 1)) != 0);
            base = m_synced ? m_exp : int'(commit_rob_id[RW-1:0]);
            o    = 1'b0;
            for (int i = 0; i < int'(IW); i++) begin
                if (commit_valid[i] && int'(commit_rob_id[i*RW +: RW]) != (base + i) % int'(NROB))
                    o = 1'b1;
            end
            t = (n == 0) && !flush && (m_idle + 1 == int'(TMO));
            if (g || o || t) begin
                m_gap = g; m_order = o; m_tmo = t;
                m_ferr  = m_cycle;
                m_state = 3;
            end else if (n > 0) begin
                m_retired += n;
                m_exp     = (base + n) % int'(NROB);
                m_synced  = 1'b1;
                m_idle    = 0;
                if (m_retired >= int'(NINSTR)) begin
                    m_state = 2;
                    m_dp    = 1'b1;
                end
            end else begin
                m_idle++;
            end
            if (flush) begin
                m_synced = 1'b0;
                m_idle   = 0;
            end
            m_cycle++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".state"},   32'(state),           32'(m_state));
        chk({tag, ".retired"}, retired_count,        32'(m_retired));
        chk({tag, ".exp_id"},  32'(expected_rob_id), 32'(m_exp));
        chk({tag, ".cycle"},   cycle_count,          32'(m_cycle));
        chk({tag, ".flags"},   32'({timeout, gap_error, order_error}), 32'({m_tmo, m_gap, m_order}));
        chk({tag, ".ferr"},    first_err_cycle,      32'(m_ferr));
        chk({tag, ".done"},    32'(done),            32'(m_state == 2));
        chk({tag, ".dpulse"},  32'(done_pulse),      32'(m_dp));
    endtask

    function automatic void add(input logic r, input logic e, input logic f, input logic [2:0] v,
                                input int a, input int b, input int c, input int st, input int ret,
                                input int eid, input logic [2:0] flg, input logic dp,
                                input int cyc, input int ferr);
        vec_t x;
        x.rst = r; x.en = e; x.fl = f; x.v = v; x.i0 = a; x.i1 = b; x.i2 = c;
        x.st = st; x.ret = ret; x.eid = eid; x.flg = flg; x.dp = dp; x.cyc = cyc; x.ferr = ferr;
        vecs.push_back(x);
    endfunction

    function automatic void build_table();
        // Full program of 11 triple commits reaching done
        add(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 0, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
        for (int k = 0; k < 11; k++)
            add(0, 0, 0, 3'b111, 3*k, 3*k+1, 3*k+2, (k == 10) ? 2 : 1, 3*(k+1), 3*(k+1),
                3'b000, k == 10, k + 1, 0);
        add(0, 0, 0, 3'b111, 33, 34, 35, 2, 33, 33, 3'b000, 0, 11, 0);
        add(0, 1, 0, 3'b000, 0, 0, 0, 2, 33, 33, 3'b000, 0, 11, 0);
        // Wrap from 45, then a holed mask
        add(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 0, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
        add(0, 0, 0, 3'b111, 45, 46, 47, 1, 3, 0, 3'b000, 0, 1, 0);
        add(0, 0, 0, 3'b111, 0, 1, 2, 1, 6, 3, 3'b000, 0, 2, 0);
        add(0, 0, 0, 3'b101, 3, 9, 5, 3, 6, 3, 3'b010, 0, 3, 2);
        add(0, 0, 0, 3'b111, 6, 7, 8, 3, 6, 3, 3'b010, 0, 3, 2);
        // Out-of-order id on lane 0
        add(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 0, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
        add(0, 0, 0, 3'b111, 0, 1, 2, 1, 3, 3, 3'b000, 0, 1, 0);
        add(0, 0, 0, 3'b111, 3, 4, 5, 1, 6, 6, 3'b000, 0, 2, 0);
        add(0, 0, 0, 3'b001, 6, 0, 0, 1, 7, 7, 3'b000, 0, 3, 0);
        add(0, 0, 0, 3'b001, 8, 0, 0, 3, 7, 7, 3'b001, 0, 4, 3);
        add(0, 0, 0, 3'b111, 7, 8, 9, 3, 7, 7, 3'b001, 0, 4, 3);
        // Flush with a commit, then resync at 20, then reset mid-run
        add(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 0, 3'b000, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0);
        add(0, 0, 0, 3'b111, 0, 1, 2, 1, 3, 3, 3'b000, 0, 1, 0);
        add(0, 0, 0, 3'b111, 3, 4, 5, 1, 6, 6, 3'b000, 0, 2, 0);
        add(0, 0, 0, 3'b111, 6, 7, 8, 1, 9, 9, 3'b000, 0, 3, 0);
        add(0, 0, 0, 3'b001, 9, 0, 0, 1, 10, 10, 3'b000, 0, 4, 0);
        add(0, 0, 1, 3'b001, 10, 0, 0, 1, 11, 11, 3'b000, 0, 5, 0);
        add(0, 0, 0, 3'b001, 20, 0, 0, 1, 12, 21, 3'b000, 0, 6, 0);
        add(1, 0, 0, 3'b111, 21, 22, 23, 0, 0, 0, 3'b000, 0, 0, 0);
    endfunction

    initial begin
        int gen_next, r, n, lane;
        logic [2:0] m;

        rst = 1'b1; enable = 1'b0; flush = 1'b0; commit_valid = '0; commit_rob_id = '0;

        // Directed vector table
        build_table();
        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].rst; enable = vecs[k].en; flush = vecs[k].fl;
            commit_valid = vecs[k].v;
            set_ids(vecs[k].i0, vecs[k].i1, vecs[k].i2);
            tick();
            chk($sformatf("row%0d.state", k),   32'(state), 32'(vecs[k].st));
            chk($sformatf("row%0d.retired", k), retired_count, 32'(vecs[k].ret));
            chk($sformatf("row%0d.exp_id", k),  32'(expected_rob_id), 32'(vecs[k].eid));
            chk($sformatf("row%0d.flags", k),   32'({timeout, gap_error, order_error}), 32'(vecs[k].flg));
            chk($sformatf("row%0d.dpulse", k),  32'(done_pulse), 32'(vecs[k].dp));
            chk($sformatf("row%0d.done", k),    32'(done), 32'(vecs[k].st == 2));
            chk($sformatf("row%0d.cycle", k),   cycle_count, 32'(vecs[k].cyc));
            chk($sformatf("row%0d.ferr", k),    first_err_cycle, 32'(vecs[k].ferr));
        end

        // Watchdog expiry after TMO idle cycles
        rst = 1'b1; enable = 1'b0; flush = 1'b0; commit_valid = '0; tick();
        rst = 1'b0; enable = 1'b1; tick(); enable = 1'b0;
        repeat (TMO - 1) tick();
        chk("to.state_pre", 32'(state), 32'd1);
        chk("to.flag_pre", 32'(timeout), 32'd0);
        tick();
        chk("to.flag", 32'(timeout), 32'd1);
        chk("to.state", 32'(state), 32'd3);
        chk("to.ferr", first_err_cycle, 32'(TMO - 1));
        chk("to.cycle", cycle_count, 32'(TMO));

        // A commit in the last cycle before expiry restarts the watchdog
        rst = 1'b1; tick();
        rst = 1'b0; enable = 1'b1; tick(); enable = 1'b0;
        repeat (TMO - 1) tick();
        commit_valid = 3'b001; set_ids(0, 0, 0); tick(); commit_valid = '0;
        chk("wd.flag", 32'(timeout), 32'd0);
        chk("wd.state", 32'(state), 32'd1);
        chk("wd.retired", retired_count, 32'd1);
        repeat (TMO - 1) tick();
        chk("wd.flag_pre", 32'(timeout), 32'd0);
        tick();
        chk("wd.flag_post", 32'(timeout), 32'd1);
        chk("wd.state_post", 32'(state), 32'd3);

        // Randomized commit streams against the model
        for (int ep = 0; ep < 80; ep++) begin
            rst = 1'b1; enable = 1'b0; flush = 1'b0; commit_valid = '0; tick();
            rst = 1'b0;
            commit_valid = 3'($urandom_range(0, 7)); commit_rob_id = 18'($urandom);
            tick(); compare_model("rnd_idle");
            enable = 1'b1; tick(); compare_model("rnd_en"); enable = 1'b0;
            gen_next = $urandom_range(0, NROB - 1);
            for (int c = 0; c < 100 && m_state == 1; c++) begin
                r = $urandom_range(0, 99);
                n = (r < 20) ? 0 : $urandom_range(1, 3);
                m = 3'((1 << n) - 1);
                for (int i = 0; i < 3; i++) begin
                    lane = (gen_next + i) % int'(NROB);
                    commit_rob_id[i*RW +: RW] = RW'(lane);
                end
                flush = ($urandom_range(0, 99) < 6);
                if (r >= 90 && r < 93) m = 3'($urandom_range(0, 7));
                if (r >= 93 && r < 96)
                    commit_rob_id[$urandom_range(0, 2)*RW +: RW] = RW'($urandom_range(0, NROB - 1));
                commit_valid = m;
                gen_next = (gen_next + n) % int'(NROB);
                if (flush) gen_next = $urandom_range(0, NROB - 1);
                tick();
                compare_model("rnd_run");
            end
            flush = 1'b0; enable = 1'b1;
            commit_valid = 3'($urandom_range(0, 7)); commit_rob_id = 18'($urandom);
            tick(); compare_model("rnd_end");
            enable = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_stream_monitor.md
Name: commit_stream_monitor

Overview:
- Synthesizable retirement monitor that consumes the processor top's commit outputs (commit_valid, commit_rob_id) alongside the top in the bench and in FPGA debug builds.
- Checks in-order, lane-contiguous commit with ROB-index wrap-around, counts retired instructions, and reports completion after the expected program length.
- Flags stalls with a no-commit watchdog.
- Gives the bench a single pass/fail/done indication instead of a fixed-time finish.

Parameters:
ISSUE_WIDTH, 3, commit lanes per cycle
NO_ROB, 48, ROB entries; index wraps at this value (not necessarily a power of 2)
NO_INSTR, 33, retirements required to declare done
TIMEOUT_CYCLES, 1024, consecutive no-commit cycles in RUN before timeout
ROB_W, $clog2(NO_ROB), ROB index width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  start monitoring (tie to init_done); sampled in IDLE only
flush  in  1  pipeline flush; forces re-sync of expected ROB id
commit_valid  in  ISSUE_WIDTH  per-lane commit strobe, lane 0 oldest
commit_rob_id  in  ISSUE_WIDTH*ROB_W  packed ids, lane i at [i*ROB_W +: ROB_W]
state  out  2  0=IDLE 1=RUN 2=DONE 3=FAIL
retired_count  out  32  total instructions retired while in RUN
expected_rob_id  out  ROB_W  next ROB id expected on lane 0
cycle_count  out  32  cycles spent in RUN
order_error  out  1  sticky: a lane id did not match the expected id
gap_error  out  1  sticky: commit_valid mask not contiguous from lane 0
timeout  out  1  sticky: watchdog expired
first_err_cycle  out  32  cycle_count value at the first error
done  out  1  level: state==DONE
done_pulse  out  1  one-cycle pulse on entry to DONE

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset, including mid-operation: every output 0, state IDLE, synced flag 0, idle counter 0.
- All outputs registered. A commit sampled at edge N is reflected in the outputs after edge N.
- IDLE:
  - enable=1 -> RUN.
  - Counters cleared; synced=0.
  - Commits in IDLE are ignored.
- RUN, each cycle:
  - cycle_count += 1.
  - n = popcount(commit_valid).
  - Legal masks are 000, 001, 011 and 111 (generalised: ones contiguous from bit 0). Any other mask sets gap_error.
  - Base id = expected_rob_id if synced, else lane-0 id (the first commit after IDLE or flush self-syncs).
  - Each valid lane i must carry (base+i) mod NO_ROB. Compute with a compare-and-subtract: if base+i >= NO_ROB, subtract NO_ROB. No power-of-2 masking. A mismatch sets order_error.
  - n>0 with no error: retired_count += n; expected_rob_id = (base+n) mod NO_ROB; synced=1; idle counter = 0.
  - n=0: idle counter += 1. When it reaches TIMEOUT_CYCLES, set timeout.
  - Any error (gap, order, timeout) in a cycle -> FAIL next cycle. first_err_cycle latches the current cycle_count on the first error only. retired_count is not updated in the erroring cycle.
  - retired_count+n >= NO_INSTR with no error -> DONE; done_pulse=1 for exactly one cycle.
  - If an error and completion occur in the same cycle, the error wins and the block goes to FAIL.
- flush in RUN: synced=0 and idle counter=0 after the edge. If flush and a commit arrive in the same cycle, the commit is checked against the old expectation first, then synced is cleared.
- DONE and FAIL:
  - Absorbing until rst.
  - Counters and flags frozen.
  - Inputs ignored; enable has no effect.
- cycle_count and retired_count saturate at 2^32-1.

Test Plan:
- rst, enable=1, then 11 cycles of mask 111 with ids {0,1,2},{3,4,5},...,{30,31,32} -> retired_count=33, expected_rob_id=33, done_pulse one cycle, state=2, no error flags.
- Sync at id 45, masks 111,111 -> ids {45,46,47},{0,1,2} accepted; expected_rob_id=3; order_error=0.
- In RUN, mask 101 -> gap_error=1, state=3 next cycle, first_err_cycle = cycle_count of the offending cycle, retired_count unchanged.
- Expected id 7, lane 0 carries 8 -> order_error=1, FAIL; further commits do not change retired_count.
- enable=1, no commits for 1024 cycles -> timeout=1 after the 1024th idle cycle, state=3; a commit at cycle 1023 resets the watchdog instead.
- Expected id 10, flush together with lane-0 id 10, next commit id 20 -> both accepted, expected_rob_id=21; rst mid-RUN -> all outputs 0, state IDLE.
